// File: rtl/axi4_lite_arb2_pkg.sv
// Shared types for the two-master AXI4-lite arbiter: FSM state encodings and
// the AXI response codes the arbiter forwards from the slave.
package axi4_lite_arb2_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_rr_arb2.sv
// Two-way round-robin grant. The grant index is combinational; the last
// winner is remembered only when the owning FSM commits the grant.
module axi4_lite_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic last_q;

  // On a tie the master that did not win last time takes the path.
  always_comb grant = (req[0] & req[1]) ? ~last_q : req[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (advance && (|req)) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/axi4_lite_arb2.sv
// Two-master to one-slave AXI4-lite arbiter with independent write and read
// paths, each holding a single outstanding transaction.
module axi4_lite_arb2
  import axi4_lite_arb2_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic [2:0]        m0_awprot,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_bvalid,
  input  logic              m0_bready,
  output logic [1:0]        m0_bresp,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [2:0]        m0_arprot,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [31:0]       m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [2:0]        m1_awprot,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [2:0]        m1_arprot,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [31:0]       m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [2:0]        s_awprot,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [2:0]        s_arprot,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [31:0]       s_rdata,
  input  logic [1:0]        s_rresp
);

  wr_state_e wr_st;
  rd_state_e rd_st;
  logic      wr_gnt, rd_gnt;
  logic      wr_arb_gnt, rd_arb_gnt;
  logic      aw_done, w_done;
  logic      aw_hs, w_hs, b_hs, ar_hs, r_hs;

  axi4_lite_rr_arb2 u_wr_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     ({m1_awvalid, m0_awvalid}),
    .advance (wr_st == W_IDLE),
    .grant   (wr_arb_gnt)
  );

  axi4_lite_rr_arb2 u_rd_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     ({m1_arvalid, m0_arvalid}),
    .advance (rd_st == R_IDLE),
    .grant   (rd_arb_gnt)
  );

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid  & s_wready;
  assign b_hs  = s_bvalid  & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid  & s_rready;

  // AW and W may complete in either order; each is forwarded only until accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_st   <= W_IDLE;
      wr_gnt  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wr_st)
        W_IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (m0_awvalid || m1_awvalid) begin
            wr_gnt <= wr_arb_gnt;
            wr_st  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wr_st   <= W_RESP;
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end
        W_RESP: if (b_hs) wr_st <= W_IDLE;
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_st  <= R_IDLE;
      rd_gnt <= 1'b0;
    end else begin
      case (rd_st)
        R_IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            rd_gnt <= rd_arb_gnt;
            rd_st  <= R_ADDR;
          end
        end
        R_ADDR: if (ar_hs) rd_st <= R_DATA;
        R_DATA: if (r_hs) rd_st <= R_IDLE;
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awprot   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    m0_bresp   = '0;
    m1_bresp   = '0;
    if (wr_st == W_ADDR) begin
      s_awvalid = (wr_gnt ? m1_awvalid : m0_awvalid) & ~aw_done;
      s_awaddr  = wr_gnt ? m1_awaddr : m0_awaddr;
      s_awprot  = wr_gnt ? m1_awprot : m0_awprot;
      s_wvalid  = (wr_gnt ? m1_wvalid : m0_wvalid) & ~w_done;
      s_wdata   = wr_gnt ? m1_wdata : m0_wdata;
      s_wstrb   = wr_gnt ? m1_wstrb : m0_wstrb;
      if (wr_gnt) begin
        m1_awready = s_awready & ~aw_done;
        m1_wready  = s_wready & ~w_done;
      end else begin
        m0_awready = s_awready & ~aw_done;
        m0_wready  = s_wready & ~w_done;
      end
    end
    if (wr_st == W_RESP) begin
      s_bready = wr_gnt ? m1_bready : m0_bready;
      if (wr_gnt) begin
        m1_bvalid = s_bvalid;
        m1_bresp  = s_bresp;
      end else begin
        m0_bvalid = s_bvalid;
        m0_bresp  = s_bresp;
      end
    end
  end

  always_comb begin
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arprot   = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = '0;
    m1_rresp   = '0;
    if (rd_st == R_ADDR) begin
      s_arvalid = rd_gnt ? m1_arvalid : m0_arvalid;
      s_araddr  = rd_gnt ? m1_araddr : m0_araddr;
      s_arprot  = rd_gnt ? m1_arprot : m0_arprot;
      if (rd_gnt) m1_arready = s_arready;
      else        m0_arready = s_arready;
    end
    if (rd_st == R_DATA) begin
      s_rready = rd_gnt ? m1_rready : m0_rready;
      if (rd_gnt) begin
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
      end
    end
  end

endmodule

// File: doc/axi4_lite_arb2.md
AXI4_LITE_ARB2 -- requirements
Module: axi4_lite_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: width of every awaddr/araddr.
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have, for each master k in {m0, m1}, port group mk_aw{valid in 1, ready out 1, addr in ADDR_W, prot in 3}  write-address channel from master k.
REQ-005 SHALL have port group mk_w{valid in 1, ready out 1, data in 32, strb in 4}  write-data channel from master k.
REQ-006 SHALL have port group mk_b{valid out 1, ready in 1, resp out 2}  write-response channel to master k.
REQ-007 SHALL have port group mk_ar{valid in 1, ready out 1, addr in ADDR_W, prot in 3}  read-address channel from master k.
REQ-008 SHALL have port group mk_r{valid out 1, ready in 1, data out 32, resp out 2}  read-data channel to master k.
REQ-009 SHALL have port group s_{aw,w,b,ar,r}*  mirror of REQ-004..008 with directions reversed  single shared AXI4-lite slave.

Function
REQ-010 Write and read paths SHALL be arbitrated independently; one write and one read may be in flight concurrently.
REQ-011 Each path SHALL hold at most one outstanding transaction.
REQ-012 Write FSM states SHALL be W_IDLE, W_ADDR, W_RESP; read FSM states R_IDLE, R_ADDR, R_DATA.
REQ-013 W_IDLE: when any mk_awvalid=1, SHALL register a grant and go to W_ADDR next cycle; no ready asserted in W_IDLE.
REQ-014 Grant SHALL be round-robin: single requester wins; with both requesting, the master not granted last on that path wins; after reset last-grant points to m1 (so m0 wins first tie).
REQ-015 W_ADDR: s_aw*/s_w* SHALL be driven from the granted master combinationally; granted mk_awready/mk_wready = s_awready/s_wready; non-granted readies = 0.
REQ-016 W_ADDR SHALL track AW and W acceptance separately (valid&ready) and go to W_RESP in the cycle after both are done, in either order or simultaneously.
REQ-017 W_RESP: s_bvalid/s_bresp SHALL route to granted mk_b*; s_bready = granted mk_bready; on s_bvalid&s_bready return to W_IDLE.
REQ-018 Read FSM SHALL mirror REQ-013..017: R_IDLE grant on mk_arvalid, R_ADDR forwards ar until s_arvalid&s_arready, R_DATA routes r channel until s_rvalid&s_rready.
REQ-019 Non-granted mk_bvalid/mk_rvalid SHALL be 0; s_*valid SHALL be 0 outside the forwarding state; ungranted data outputs SHALL be 0.
REQ-020 Arbitration latency SHALL be exactly 1 cycle from valid in IDLE to s_*valid high.
REQ-021 Slave responses (SLVERR/DECERR) SHALL pass through unmodified; the block never generates responses.
REQ-022 Request of the non-granted master SHALL remain pending (not dropped) and win the next IDLE cycle.

Reset
REQ-023 On rst_n_i low both FSMs SHALL go to IDLE, last-grant to m1, AW/W-done flags to 0, all valid/ready outputs 0, data outputs 0.
REQ-024 Reset mid-transaction SHALL abandon it; no response reaches any master after release.

Structure
REQ-025 Shared package SHALL hold the write/read FSM state enums and AXI response constants (OKAY=2'b00, SLVERR=2'b10).
REQ-026 One sub-module axi4_lite_rr_arb2 (2-way round-robin grant: req[1:0], advance, grant) SHALL be instantiated once per path.

Verification
REQ-027 m0 write addr 3'h4 data 32'hCAFE0001 strb 4'hF, slave OKAY -> s_awaddr=4, s_wdata=CAFE0001, m0_bresp=00, m1 untouched.
REQ-028 m0 and m1 awvalid same cycle, twice in a row -> first grant m0, then m1, then m0; no transaction lost.
REQ-029 Slave accepts W two cycles before AW -> single s_bready phase, FSM enters W_RESP only after AW accepted.
REQ-030 m1 read addr 3'h0 concurrent with m0 write -> both complete; m1_rdata = s_rdata, m0_bvalid independent of read.
REQ-031 Slave rresp=2'b10 with m0_rready held low 3 cycles -> s_rready low 3 cycles, m0_rresp=10 once handshake completes.
REQ-032 rst_n_i pulsed low in W_RESP -> all outputs 0 next cycle, late s_bvalid not forwarded, new write proceeds normally.
